// File: rtl/trans_counter_bank_pkg.sv
// Shared defaults and helpers for the transition-counter bank.
package trans_counter_bank_pkg;

  localparam int DEF_NUM_CH = 5;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_MON_W  = 32;
  localparam int DEF_CNTR_W = 32;

  localparam bit SAT_MODE  = 1'b1;
  localparam bit WRAP_MODE = 1'b0;

  // Width needed to hold a Hamming distance of 0..mon_w.
  function automatic int popcnt_w(input int mon_w);
    return $clog2(mon_w + 1);
  endfunction

endpackage

// File: rtl/trans_counter_bank_chan.sv
// One monitored channel: sample history, primed flag, Hamming-distance
// accumulator with saturate/wrap overflow handling and sticky overflow flag.
module trans_counter_bank_chan
  import trans_counter_bank_pkg::*;
#(
  parameter int MON_W    = DEF_MON_W,
  parameter int CNTR_W   = DEF_CNTR_W,
  parameter bit SATURATE = SAT_MODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MON_W-1:0]  sample,
  input  logic              valid,
  input  logic              cnt_en,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [CNTR_W-1:0] wr_data,
  output logic [CNTR_W-1:0] cnt,
  output logic              ovf
);

  localparam int PCW = popcnt_w(MON_W);

  logic [MON_W-1:0]  prev_q, prev_d;
  logic              primed_q, primed_d;
  logic [CNTR_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [MON_W-1:0]  diff;
  logic [PCW-1:0]    delta;
  logic [CNTR_W:0]   sum;

  always_comb begin
    diff  = prev_q ^ sample;
    delta = '0;
    for (int b = 0; b < MON_W; b++) begin
      delta = delta + PCW'(diff[b]);
    end
    // Extra top bit of sum is the carry that signals overflow.
    sum = {1'b0, cnt_q} + {{(CNTR_W + 1 - PCW){1'b0}}, delta};
  end

  always_comb begin
    prev_d   = prev_q;
    primed_d = primed_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (valid) begin
      prev_d   = sample;
      primed_d = 1'b1;
      if (primed_q && cnt_en) begin
        if (sum[CNTR_W]) begin
          ovf_d = 1'b1;
          if (SATURATE == WRAP_MODE) begin
            cnt_d = sum[CNTR_W-1:0];
          end else begin
            cnt_d = '1;
          end
        end else begin
          cnt_d = sum[CNTR_W-1:0];
        end
      end
    end

    // Host write replaces any same-cycle increment; history still advances.
    if (wr_en) begin
      cnt_d = wr_data;
      ovf_d = 1'b0;
    end

    if (clr) begin
      prev_d   = '0;
      primed_d = 1'b0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/trans_counter_bank.sv
// Bank of NUM_CH toggle counters with a registered read/write port
// addressed by channel index; out-of-range addresses raise addr_err.
module trans_counter_bank
  import trans_counter_bank_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MON_W    = DEF_MON_W,
  parameter int CNTR_W   = DEF_CNTR_W,
  parameter bit SATURATE = SAT_MODE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*MON_W-1:0] mon_data,
  input  logic [NUM_CH-1:0]       mon_valid,
  input  logic                    cnt_en,
  input  logic                    clr,
  input  logic [ADDR_W-1:0]       dir,
  input  logic                    wr_en,
  input  logic [CNTR_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [CNTR_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    addr_err,
  output logic [NUM_CH-1:0]       ovf
);

  logic              dir_ok;
  logic [NUM_CH-1:0] wr_sel;
  logic [CNTR_W-1:0] cnt_w [NUM_CH];
  logic [CNTR_W-1:0] rd_mux;

  logic [CNTR_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;

  // Extra bit lets NUM_CH == 2**ADDR_W compare correctly.
  assign dir_ok = ({1'b0, dir} < (ADDR_W + 1)'(NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    trans_counter_bank_chan #(
      .MON_W    (MON_W),
      .CNTR_W   (CNTR_W),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .sample  (mon_data[g*MON_W +: MON_W]),
      .valid   (mon_valid[g]),
      .cnt_en  (cnt_en),
      .clr     (clr),
      .wr_en   (wr_sel[g]),
      .wr_data (wr_data),
      .cnt     (cnt_w[g]),
      .ovf     (ovf[g])
    );
  end

  always_comb begin
    wr_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dir == ADDR_W'(i)) begin
        wr_sel[i] = wr_en;
        rd_mux    = cnt_w[i];
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    addr_err_d = (rd_en || wr_en) && !dir_ok;
    if (rd_en) begin
      rd_data_d = dir_ok ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_trans_counter_bank.sv
// Self-checking bench for trans_counter_bank: directed table, corner-case
// sequences, and randomized traffic against a behavioural model.
module tb_trans_counter_bank;

  localparam int NCH = 5;
  localparam int MW  = 32;
  localparam longint MAXV = 64'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH*MW-1:0] mon_data;
  logic [NCH-1:0]  mon_valid;
  logic            cnt_en, clr, wr_en, rd_en;
  logic [2:0]      dir;
  logic [31:0]     wr_data;
  logic [31:0]     rd_data;
  logic            rd_valid, addr_err;
  logic [NCH-1:0]  ovf;

  logic [5:0]      rd_data_s, rd_data_w;
  logic            rd_valid_s, rd_valid_w, addr_err_s, addr_err_w;
  logic [NCH-1:0]  ovf_s, ovf_w;

  always #5 clk = ~clk;

  trans_counter_bank #(.NUM_CH(5), .ADDR_W(3), .MON_W(32), .CNTR_W(32), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .mon_data(mon_data), .mon_valid(mon_valid), .cnt_en(cnt_en),
    .clr(clr), .dir(dir), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .addr_err(addr_err), .ovf(ovf));

  trans_counter_bank #(.NUM_CH(5), .ADDR_W(3), .MON_W(32), .CNTR_W(6), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .mon_data(mon_data), .mon_valid(mon_valid), .cnt_en(cnt_en),
    .clr(clr), .dir(dir), .wr_en(wr_en), .wr_data(wr_data[5:0]), .rd_en(rd_en),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s), .addr_err(addr_err_s), .ovf(ovf_s));

  trans_counter_bank #(.NUM_CH(5), .ADDR_W(3), .MON_W(32), .CNTR_W(6), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .mon_data(mon_data), .mon_valid(mon_valid), .cnt_en(cnt_en),
    .clr(clr), .dir(dir), .wr_en(wr_en), .wr_data(wr_data[5:0]), .rd_en(rd_en),
    .rd_data(rd_data_w), .rd_valid(rd_valid_w), .addr_err(addr_err_w), .ovf(ovf_w));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Behavioural reference for the 32-bit saturating instance.
  longint      m_cnt [NCH];
  logic [31:0] m_prev [NCH];
  bit          m_primed [NCH];
  bit          m_ovf [NCH];
  logic [31:0] e_rd;
  bit          e_rv, e_err;

  function automatic logic [NCH-1:0] m_ovf_vec();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_ovf[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_prev[c] = '0; m_primed[c] = 0; m_ovf[c] = 0;
    end
    e_rd = '0; e_rv = 0; e_err = 0;
  endtask

  task automatic model_step();
    int a;
    longint s;
    logic [31:0] smp;
    a = int'(dir);
    e_rv  = rd_en;
    e_err = (rd_en || wr_en) && (a >= NCH);
    if (rd_en) e_rd = (a < NCH) ? 32'(m_cnt[a]) : 32'h0;
    for (int c = 0; c < NCH; c++) begin
      if (clr) begin
        m_cnt[c] = 0; m_ovf[c] = 0; m_primed[c] = 0;
      end else begin
        smp = mon_data[c*MW +: MW];
        if (mon_valid[c]) begin
          if (m_primed[c] && cnt_en) begin
            s = m_cnt[c] + longint'($countones(m_prev[c] ^ smp));
            if (s > MAXV) begin
              m_ovf[c] = 1;
              s = MAXV;
            end
            m_cnt[c] = s;
          end
          m_prev[c] = smp;
          m_primed[c] = 1;
        end
        if (wr_en && a == c) begin
          m_cnt[c] = longint'(wr_data);
          m_ovf[c] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    mon_valid = '0; rd_en = 0; wr_en = 0; clr = 0;
  endtask

  task automatic set_sample(input int ch, input logic [31:0] d);
    mon_data[ch*MW +: MW] = d;
    mon_valid[ch] = 1'b1;
  endtask

  task automatic do_read(input int ch);
    rd_en = 1; dir = 3'(ch);
    cycle();
  endtask

  typedef struct {
    int          ch;
    logic [31:0] data;
    bit          valid;
    bit          rd;
    bit          wr;
    logic [2:0]  dir;
    logic [31:0] wdata;
    logic [31:0] e_rd;
    bit          e_rv;
    bit          e_err;
  } vec_t;

  vec_t vt [12];

  initial begin
    reset = 1; mon_data = '0; mon_valid = '0; cnt_en = 1; clr = 0;
    wr_en = 0; rd_en = 0; dir = '0; wr_data = '0;
    model_reset();

    vt[0]  = '{0, 32'h0000_0000, 1, 0, 0, 3'd0, 32'd0,   32'd0,  0, 0};
    vt[1]  = '{0, 32'hFFFF_FFFF, 1, 0, 0, 3'd0, 32'd0,   32'd0,  0, 0};
    vt[2]  = '{0, 32'h0000_FFFF, 1, 0, 0, 3'd0, 32'd0,   32'd0,  0, 0};
    vt[3]  = '{0, 32'h0,         0, 1, 0, 3'd0, 32'd0,   32'd48, 1, 0};
    vt[4]  = '{0, 32'h0,         0, 0, 0, 3'd0, 32'd0,   32'd48, 0, 0};
    vt[5]  = '{1, 32'hA5A5_A5A5, 1, 0, 0, 3'd0, 32'd0,   32'd48, 0, 0};
    vt[6]  = '{1, 32'hA5A5_A5A5, 1, 1, 0, 3'd1, 32'd0,   32'd0,  1, 0};
    vt[7]  = '{1, 32'h0,         0, 1, 0, 3'd1, 32'd0,   32'd0,  1, 0};
    vt[8]  = '{0, 32'h0,         0, 1, 0, 3'd6, 32'd0,   32'd0,  1, 1};
    vt[9]  = '{0, 32'h0,         0, 0, 1, 3'd7, 32'd123, 32'd0,  0, 1};
    vt[10] = '{0, 32'h0,         0, 1, 0, 3'd0, 32'd0,   32'd48, 1, 0};
    vt[11] = '{0, 32'h0,         0, 0, 0, 3'd0, 32'd0,   32'd48, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_addr_err", addr_err, 0);
    chk("reset_ovf", ovf, 0);
    reset = 0;

    // Directed table: basic counting, priming, invalid address.
    for (int i = 0; i < 12; i++) begin
      if (vt[i].valid) set_sample(vt[i].ch, vt[i].data);
      rd_en = vt[i].rd; wr_en = vt[i].wr; dir = vt[i].dir; wr_data = vt[i].wdata;
      cycle();
      chk($sformatf("tbl%0d_rd_data", i), rd_data, vt[i].e_rd);
      chk($sformatf("tbl%0d_rd_valid", i), rd_valid, vt[i].e_rv);
      chk($sformatf("tbl%0d_addr_err", i), addr_err, vt[i].e_err);
    end
    chk("tbl_ovf", ovf, 0);

    // Write wins over same-cycle increment; same-cycle read sees old value.
    set_sample(3, 32'h0); cycle();
    wr_en = 1; dir = 3'd3; wr_data = 32'd7; cycle();
    set_sample(3, 32'hF); wr_en = 1; rd_en = 1; dir = 3'd3; wr_data = 32'd100; cycle();
    chk("coll_rd_old", rd_data, 7);
    do_read(3);
    chk("coll_wr_new", rd_data, 100);

    // cnt_en=0 keeps history moving without counting.
    cnt_en = 0;
    set_sample(4, 32'h0); cycle();
    for (int i = 0; i < 10; i++) begin
      set_sample(4, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0); cycle();
    end
    cnt_en = 1;
    set_sample(4, 32'h1); cycle();
    do_read(4);
    chk("cnten_gate", rd_data, 1);

    // 6-bit counters: saturate vs wrap on 96 toggles.
    set_sample(2, 32'h0); cycle();
    for (int i = 0; i < 3; i++) begin
      set_sample(2, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0); cycle();
    end
    do_read(2);
    chk("sat_cnt", rd_data_s, 63);
    chk("wrap_cnt", rd_data_w, 32);
    chk("sat_ovf", ovf_s[2], 1);
    chk("wrap_ovf", ovf_w[2], 1);
    chk("main_cnt96", rd_data, 96);
    wr_en = 1; dir = 3'd2; wr_data = 32'd5; cycle();
    do_read(2);
    chk("sat_wr_cnt", rd_data_s, 5);
    chk("sat_wr_ovf", ovf_s[2], 0);
    chk("wrap_wr_ovf", ovf_w[2], 0);

    // clr overrides same-cycle sample and write.
    set_sample(0, 32'hDEAD_BEEF); set_sample(2, 32'hFFFF_FFFF);
    clr = 1; wr_en = 1; dir = 3'd1; wr_data = 32'd9; cycle();
    for (int c = 0; c < NCH; c++) begin
      do_read(c);
      chk($sformatf("clr_cnt%0d", c), rd_data, 0);
    end
    chk("clr_ovf_s", ovf_s, 0);
    set_sample(0, 32'h1234_5678); cycle();
    do_read(0);
    chk("clr_prime_only", rd_data, 0);
    set_sample(0, 32'h1234_5679); cycle();
    do_read(0);
    chk("clr_then_count", rd_data, 1);

    // Reset in the middle of a read drops it.
    rd_en = 1; dir = 3'd0;
    @(posedge clk);
    #2 reset = 1;
    rd_en = 0;
    #1;
    chk("rst_mid_rd_valid", rd_valid, 0);
    chk("rst_mid_rd_data", rd_data, 0);
    chk("rst_mid_ovf", ovf, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    set_sample(0, 32'h55); cycle();
    do_read(0);
    chk("rst_prime_only", rd_data, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      mon_valid = 5'($urandom_range(0, 31));
      for (int c = 0; c < NCH; c++)
        mon_data[c*MW +: MW] = mon_data[c*MW +: MW] ^ ($urandom & $urandom & $urandom);
      cnt_en  = ($urandom_range(0, 9) != 0);
      dir     = 3'($urandom_range(0, 7));
      rd_en   = ($urandom_range(0, 2) == 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_data = ($urandom_range(0, 1) == 1) ? 32'($urandom) : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
      clr     = ($urandom_range(0, 99) == 0);
      cycle();
      chk("rnd_rd_valid", rd_valid, e_rv);
      chk("rnd_addr_err", addr_err, e_err);
      chk("rnd_rd_data", rd_data, e_rd);
      chk("rnd_ovf", ovf, m_ovf_vec());
    end
    for (int c = 0; c < NCH; c++) begin
      do_read(c);
      chk($sformatf("final_cnt%0d", c), rd_data, e_rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trans_counter_bank.md
Name: trans_counter_bank

Overview:
- Parametrised, clocked bank of bit-transition (toggle) counters for switching-activity and power estimation.
- Each of NUM_CH channels samples a monitored bus on a valid strobe and adds the Hamming distance between the current and previous sample to its counter.
- Counters are readable and writable over a simple synchronous register port addressed by channel index.
- Sits beside the monitored datapaths in the power-measurement test harness; replaces the unclocked, single-mode counter memory.

Parameters:
NUM_CH, 5, number of monitored channels/counters (1..2**ADDR_W)
ADDR_W, 3, register-port address width
MON_W, 32, width of each monitored bus
CNTR_W, 32, counter width (must satisfy 2**CNTR_W-1 >= MON_W)
SATURATE, 1, 1 = counters saturate at all-ones, 0 = counters wrap modulo 2**CNTR_W

Ports:
clk  input  1  single clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
mon_data  input  NUM_CH*MON_W  monitored buses; channel i occupies bits [i*MON_W +: MON_W]
mon_valid  input  NUM_CH  per-channel sample strobe
cnt_en  input  1  global count enable; when 0, samples still update the history register but do not add to counters
clr  input  1  synchronous clear of all counters, overflow flags and primed bits
dir  input  ADDR_W  register-port channel address
wr_en  input  1  write strobe for counter[dir]
wr_data  input  CNTR_W  write data
rd_en  input  1  read strobe for counter[dir]
rd_data  output  CNTR_W  registered read data
rd_valid  output  1  high exactly one cycle after an accepted rd_en
addr_err  output  1  one-cycle pulse when rd_en or wr_en is asserted with dir >= NUM_CH
ovf  output  NUM_CH  sticky per-channel overflow/saturation flag

Behaviour:
- Reset (async, active-high): all counters, history registers, primed bits, ovf, rd_data, rd_valid and addr_err go to 0 immediately and stay 0 while reset is high.
- Per-channel state: prev[MON_W], primed bit, cnt[CNTR_W], ovf bit.
- Sample cycle (mon_valid[i]=1):
  - Unprimed: load prev <= sample, set primed, no count change.
  - Primed: delta = popcount(prev ^ sample), width clog2(MON_W+1); prev <= sample.
  - If cnt_en=1, cnt <= cnt + delta.
- Overflow (sum > 2**CNTR_W-1):
  - SATURATE=1: cnt <= all-ones.
  - SATURATE=0: cnt <= sum mod 2**CNTR_W.
  - In both modes ovf[i] <= 1, sticky.
- Latency: a sample at edge k is reflected in cnt after edge k; a read issued at edge k+1 returns it.
- Host write (wr_en=1, dir<NUM_CH): cnt[dir] <= wr_data and ovf[dir] <= 0.
  - Wins over a same-cycle increment on that channel; the increment is discarded.
  - prev and primed are still updated by the sample.
- Read: rd_en=1 with dir<NUM_CH gives rd_data <= cnt[dir] (pre-update value of this edge) and rd_valid <= 1 next cycle.
  - Invalid dir: rd_data <= 0, rd_valid <= 1, addr_err pulses.
  - rd_data holds its last value when rd_en=0.
- Simultaneous rd_en and wr_en to the same channel: the read returns the old value and the write takes effect.
- Write with dir >= NUM_CH: ignored, addr_err pulses.
- clr: same-edge effect as reset on counters, ovf and primed; overrides samples and writes in that cycle; rd_data and rd_valid are unaffected.
- Reset mid-operation: an in-flight read is dropped (rd_valid=0) and the first post-reset sample only primes.
- No FSM beyond the primed bit; one pipeline stage on the read path.

Decomposition:
- Shared header (trans_cntr_defs.vh): default widths, the popcount width macro (clog2(MON_W+1)) and a SAT/WRAP mode constant.
- Sub-module trans_cntr_chan: one channel containing prev, primed, the popcount-add-saturate logic, cnt and ovf.
  - Inputs: sample, valid, cnt_en, clr, write port.
- Top generates NUM_CH instances plus the address decode, read mux and error logic.

Test Plan:
- Reset then ch0 samples 0x00000000, 0xFFFFFFFF, 0x0000FFFF with cnt_en=1 -> read dir=0 gives 48 with rd_valid one cycle after rd_en; ovf=0.
- First sample after reset on ch1 = 0xA5A5A5A5, then same value -> cnt[1]=0 (priming adds nothing, no toggles).
- CNTR_W=6, SATURATE=1: alternate 0x0/0xFFFFFFFF on ch2 three times -> cnt=63, ovf[2]=1; write 5 -> cnt=5, ovf[2]=0. With SATURATE=0 the same stimulus gives cnt=96 mod 64=32, ovf[2]=1.
- Same-cycle wr_en (dir=3, data=100) and toggle of 4 bits on ch3 -> cnt[3]=100; a same-cycle rd_en to dir=3 returns the pre-write value.
- rd_en with dir=6 (NUM_CH=5) -> rd_data=0, rd_valid=1, addr_err pulses one cycle; wr_en to dir=7 -> no counter changes.
- cnt_en=0 during 10 toggling samples then cnt_en=1, one 1-bit toggle -> cnt=1. Assert clr and reset mid-stream -> all counters 0, ovf=0, next sample only primes.
